div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq.sv | 197 +++++++++++++++++++
 tb/tb_div_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential restoring divider: N-step shift-subtract with fast paths for divide-by-zero and signed overflow.
// Signed (two's-complement) operation is built only when the DIV_SIGNED_EN macro is defined.
module div_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sgn,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         dz,
  output logic         o,
  output logic         z
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r;
  logic [N-1:0]  rem_r, quo_r, div_r;
  logic [N-1:0]  q_r, r_r;
  logic          busy_r, done_r, dz_r, z_r;

  logic [N-1:0]  x_mag_s, y_mag_s;
  logic          ovf_s, dz_in_s, last_s, ge_s;
  logic [N:0]    rem_sh_s;
  logic [N-1:0]  rem_nx_s, quo_nx_s, fq_s, fr_s;

  assign dz_in_s = (y == {N{1'b0}});
  assign last_s  = (cnt_r == CNT_LAST);

  // One restoring step: remainder never exceeds the divisor, so N+1 bits hold the shifted value.
  assign rem_sh_s = {rem_r, quo_r[N-1]};
  assign ge_s     = (rem_sh_s >= {1'b0, div_r});
  assign rem_nx_s = ge_s ? N'(rem_sh_s - {1'b0, div_r}) : rem_sh_s[N-1:0];
  assign quo_nx_s = {quo_r[N-2:0], ge_s};

`ifdef DIV_SIGNED_EN
  logic x_neg_s, y_neg_s;
  logic neg_q_r, neg_r_r, o_r;

  function automatic logic [N-1:0] neg_f(input logic [N-1:0] v);
    return ~v + {{(N-1){1'b0}}, 1'b1};
  endfunction

  assign x_neg_s = sgn & x[N-1];
  assign y_neg_s = sgn & y[N-1];
  assign x_mag_s = x_neg_s ? neg_f(x) : x;
  assign y_mag_s = y_neg_s ? neg_f(y) : y;
  assign ovf_s   = sgn & (x == {1'b1, {(N-1){1'b0}}}) & (y == {N{1'b1}});
  assign fq_s    = neg_q_r ? neg_f(quo_nx_s) : quo_nx_s;
  assign fr_s    = neg_r_r ? neg_f(rem_nx_s) : rem_nx_s;
  assign o       = o_r;

  // Result sign flags captured at accept, and the overflow flag updated only on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      o_r     <= 1'b0;
    end else if (state_r == IDLE && start) begin
      neg_q_r <= x_neg_s ^ y_neg_s;
      neg_r_r <= x_neg_s;
      if (dz_in_s || ovf_s) begin
        o_r <= ovf_s & ~dz_in_s;
      end else begin
        o_r <= o_r;
      end
    end else if (state_r == CALC && last_s) begin
      o_r <= 1'b0;
    end else begin
      o_r <= o_r;
    end
  end
`else
  logic unused_sgn_s;

  assign unused_sgn_s = sgn;
  assign x_mag_s      = x;
  assign y_mag_s      = y;
  assign ovf_s        = 1'b0;
  assign fq_s         = quo_nx_s;
  assign fr_s         = rem_nx_s;
  assign o            = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start outside IDLE is ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (dz_in_s || ovf_s) ? DONE : CALC;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath and result registers; results change only on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= {CW{1'b0}};
      rem_r  <= {N{1'b0}};
      quo_r  <= {N{1'b0}};
      div_r  <= {N{1'b0}};
      q_r    <= {N{1'b0}};
      r_r    <= {N{1'b0}};
      dz_r   <= 1'b0;
      z_r    <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == CALC);
      done_r <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r <= {CW{1'b0}};
            if (dz_in_s) begin
              q_r  <= {N{1'b1}};
              r_r  <= x;
              dz_r <= 1'b1;
              z_r  <= 1'b0;
            end else if (ovf_s) begin
              q_r  <= x;
              r_r  <= {N{1'b0}};
              dz_r <= 1'b0;
              z_r  <= 1'b0;
            end else begin
              rem_r <= {N{1'b0}};
              quo_r <= x_mag_s;
              div_r <= y_mag_s;
            end
          end
        end
        CALC: begin
          rem_r <= rem_nx_s;
          quo_r <= quo_nx_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (last_s) begin
            q_r  <= fq_s;
            r_r  <= fr_s;
            dz_r <= 1'b0;
            z_r  <= (fq_s == {N{1'b0}});
          end
        end
        DONE: begin
          cnt_r <= {CW{1'b0}};
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign q    = q_r;
  assign r    = r_r;
  assign dz   = dz_r;
  assign z    = z_r;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq (N=8): vector table plus hand-written mid-CALC start and reset sequences.
module tb_div_seq;
  localparam int N = 8;
`ifdef DIV_SIGNED_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start, sgn;
  logic [N-1:0] x, y, q, r;
  logic         busy, done, dz, o, z;

  int checks = 0;
  int passed = 0;

  div_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .sgn(sgn),
    .busy(busy), .done(done), .q(q), .r(r), .dz(dz), .o(o), .z(z)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] x, y;
    logic       s;
    logic [7:0] q, r;
    logic       dz, o, z;
    int         lat, bc;
  } vec_t;

  vec_t v[12];

  // Starts a division, returns edges from the accepting edge to done and the busy cycle count.
  task automatic run_div(input logic [7:0] xi, input logic [7:0] yi, input logic si,
                         output int lat, output int bc);
    @(negedge clk);
    x = xi; y = yi; sgn = si; start = 1'b1;
    @(posedge clk);
    lat = 1; bc = 0;
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat, bc, cnt;
    logic [7:0] qs, rs;

    v[0]  = '{8'd100, 8'd7,   1'b0, 8'd14,  8'd2,   1'b0, 1'b0, 1'b0, 9, 8};
    v[1]  = '{8'd5,   8'd0,   1'b0, 8'hFF,  8'd5,   1'b1, 1'b0, 1'b0, 1, 0};
    v[2]  = '{8'd3,   8'd9,   1'b0, 8'd0,   8'd3,   1'b0, 1'b0, 1'b1, 9, 8};
    v[3]  = '{8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   1'b0, 1'b0, 1'b0, 9, 8};
    v[4]  = '{8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   1'b0, 1'b0, 1'b0, 9, 8};
    v[5]  = '{8'd0,   8'd5,   1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 1'b1, 9, 8};
    v[6]  = '{8'd200, 8'd13,  1'b0, 8'd15,  8'd5,   1'b0, 1'b0, 1'b0, 9, 8};
    v[7]  = '{8'h85,  8'd0,   1'b1, 8'hFF,  8'h85,  1'b1, 1'b0, 1'b0, 1, 0};
    // sgn=1 rows: signed expectations when enabled, otherwise sgn is ignored.
    v[8]  = SE ? '{8'hF9, 8'd2,  1'b1, 8'hFD, 8'hFF, 1'b0, 1'b0, 1'b0, 9, 8}
               : '{8'hF9, 8'd2,  1'b1, 8'd124, 8'd1, 1'b0, 1'b0, 1'b0, 9, 8};
    v[9]  = SE ? '{8'h80, 8'hFF, 1'b1, 8'h80, 8'd0,  1'b0, 1'b1, 1'b0, 1, 0}
               : '{8'h80, 8'hFF, 1'b1, 8'd0,  8'h80, 1'b0, 1'b0, 1'b1, 9, 8};
    v[10] = SE ? '{8'h80, 8'd3,  1'b1, 8'hD6, 8'hFE, 1'b0, 1'b0, 1'b0, 9, 8}
               : '{8'h80, 8'd3,  1'b1, 8'h2A, 8'd2,  1'b0, 1'b0, 1'b0, 9, 8};
    v[11] = SE ? '{8'd7,  8'hFE, 1'b1, 8'hFD, 8'd1,  1'b0, 1'b0, 1'b0, 9, 8}
               : '{8'd7,  8'hFE, 1'b1, 8'd0,  8'd7,  1'b0, 1'b0, 1'b1, 9, 8};

    rst_n = 1'b0; start = 1'b0; x = 8'd0; y = 8'd0; sgn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, q, r, dz, o, z}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_div(v[i].x, v[i].y, v[i].s, lat, bc);
      check($sformatf("v%0d_q", i),    q,   v[i].q);
      check($sformatf("v%0d_r", i),    r,   v[i].r);
      check($sformatf("v%0d_flags", i), {dz, o, z}, {v[i].dz, v[i].o, v[i].z});
      check($sformatf("v%0d_latency", i), lat, v[i].lat);
      check($sformatf("v%0d_busy_cycles", i), bc, v[i].bc);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), {done, busy}, 2'b00);
      check($sformatf("v%0d_q_held", i), q, v[i].q);
    end

    // start with different operands during CALC must be ignored.
    @(negedge clk);
    x = 8'd100; y = 8'd7; sgn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    x = 8'd50; y = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; x = 8'd0; y = 8'd0;
    cnt = 0; qs = 8'd0; rs = 8'd0;
    repeat (20) begin
      @(negedge clk);
      if (done) begin
        cnt++; qs = q; rs = r;
      end
    end
    check("calc_start_done_count", cnt, 1);
    check("calc_start_q", qs, 8'd14);
    check("calc_start_r", rs, 8'd2);

    // Reset in the 4th CALC cycle aborts with no done pulse.
    @(negedge clk);
    x = 8'd100; y = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_calc_reset_outputs", {busy, done, q, r, dz, o, z}, 32'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) cnt++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("reset_no_done", cnt, 0);
    run_div(8'd100, 8'd7, 1'b0, lat, bc);
    check("post_reset_q", q, 8'd14);
    check("post_reset_r", r, 8'd2);
    check("post_reset_latency", lat, 9);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
